// File: rtl/rs_rotator_pipe.sv
// Two-stage pipelined 8-PSK rotator: each lane computes R*exp(j*k*pi/4) with a shared valid/ready/tag.
// Optional macro RS_ROTATOR_SAT_EN saturates the final WIDTH-bit reduction instead of wrapping.
module rs_rotator_pipe #(
  parameter int WIDTH     = 16,
  parameter int LANES     = 2,
  parameter int COEF      = 181,
  parameter int COEF_FRAC = 8,
  parameter int TAG_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] R_real,
  input  logic [LANES*WIDTH-1:0] R_imag,
  input  logic [LANES*3-1:0]     S,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] Out_real,
  output logic [LANES*WIDTH-1:0] Out_imag,
  output logic [TAG_W-1:0]       out_tag
);
  // Guard bit beyond WIDTH+1 keeps -Rr-Ri exact when both inputs sit at the negative corner.
  localparam int AW = WIDTH + 2;
  localparam int PW = WIDTH + 2 + COEF_FRAC;
  localparam logic signed [COEF_FRAC+1:0] COEF_S = (COEF_FRAC + 2)'(COEF);
`ifdef RS_ROTATOR_SAT_EN
  localparam logic signed [PW-1:0] MAX_S = PW'((32'sd1 <<< (WIDTH - 1)) - 32'sd1);
  localparam logic signed [PW-1:0] MIN_S = PW'(-(32'sd1 <<< (WIDTH - 1)));
`endif

  function automatic logic [WIDTH-1:0] reduce_w(input logic signed [PW-1:0] v);
    logic [WIDTH-1:0] r;
`ifdef RS_ROTATOR_SAT_EN
    if (v > MAX_S) begin
      r = WIDTH'(MAX_S);
    end else if (v < MIN_S) begin
      r = WIDTH'(MIN_S);
    end else begin
      r = WIDTH'(v);
    end
`else
    r = WIDTH'(v);
`endif
    return r;
  endfunction

  logic             en_s;
  logic             s1_valid_q;
  logic             out_valid_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [TAG_W-1:0] out_tag_q;

  assign en_s      = ~out_valid_q | out_ready;
  assign in_ready  = en_s;
  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;

  // Valid and tag shift through both stages together on the global advance enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
    end else if (en_s) begin
      s1_valid_q  <= in_valid;
      s1_tag_q    <= in_tag;
      out_valid_q <= s1_valid_q;
      out_tag_q   <= s1_tag_q;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [AW-1:0]    rr_s, ri_s, x_d, y_d, x_q, y_q;
    logic                    diag_d, diag_q;
    logic signed [PW-1:0]    px_s, py_s, rx_s, ry_s;
    logic        [WIDTH-1:0] re_d, im_d, re_q, im_q;

    assign rr_s = AW'($signed(R_real[g*WIDTH +: WIDTH]));
    assign ri_s = AW'($signed(R_imag[g*WIDTH +: WIDTH]));

    // Gray-coded symbol to exact axis rotation or unscaled diagonal sum/difference.
    always_comb begin
      x_d    = rr_s;
      y_d    = ri_s;
      diag_d = 1'b0;
      case (S[g*3 +: 3])
        3'd7: begin x_d = rr_s;         y_d = ri_s;         diag_d = 1'b0; end
        3'd6: begin x_d = rr_s - ri_s;  y_d = rr_s + ri_s;  diag_d = 1'b1; end
        3'd2: begin x_d = -ri_s;        y_d = rr_s;         diag_d = 1'b0; end
        3'd3: begin x_d = -rr_s - ri_s; y_d = rr_s - ri_s;  diag_d = 1'b1; end
        3'd1: begin x_d = -rr_s;        y_d = -ri_s;        diag_d = 1'b0; end
        3'd0: begin x_d = ri_s - rr_s;  y_d = -rr_s - ri_s; diag_d = 1'b1; end
        3'd4: begin x_d = ri_s;         y_d = -rr_s;        diag_d = 1'b0; end
        3'd5: begin x_d = rr_s + ri_s;  y_d = ri_s - rr_s;  diag_d = 1'b1; end
        default: begin x_d = rr_s;      y_d = ri_s;         diag_d = 1'b0; end
      endcase
    end

    assign px_s = PW'(x_q) * PW'(COEF_S);
    assign py_s = PW'(y_q) * PW'(COEF_S);
    // Arithmetic shift gives floor rounding of the 1/sqrt(2) scaling.
    assign rx_s = diag_q ? (px_s >>> COEF_FRAC) : PW'(x_q);
    assign ry_s = diag_q ? (py_s >>> COEF_FRAC) : PW'(y_q);
    assign re_d = reduce_w(rx_s);
    assign im_d = reduce_w(ry_s);

    // Stage-1 operands and stage-2 results for this lane, gated by the shared enable.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        x_q    <= '0;
        y_q    <= '0;
        diag_q <= 1'b0;
        re_q   <= '0;
        im_q   <= '0;
      end else if (en_s) begin
        x_q    <= x_d;
        y_q    <= y_d;
        diag_q <= diag_d;
        re_q   <= re_d;
        im_q   <= im_d;
      end
    end

    assign Out_real[g*WIDTH +: WIDTH] = re_q;
    assign Out_imag[g*WIDTH +: WIDTH] = im_q;
  end

endmodule
